// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and helpers for the multi-port register file
//
// Purpose : default geometry, safe clog2 and the write-collision winner picker
//           shared by the storage write path and the read bypass path.
// Ports   : none (package).
package regfile_pkg;

  localparam int DW_DEF   = 16;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = 5;

  // Upper bound on write ports accepted by win_port (hit vectors are zero-extended).
  localparam int MAX_NWR  = 32;

  // Address width that never collapses to zero for tiny register counts.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Highest-index write port targeting an address wins; -1 when no port hits.
  function automatic int win_port(input logic [MAX_NWR-1:0] hit);
    int w;
    w = -1;
    for (int j = 0; j < MAX_NWR; j++) begin
      if (hit[j]) w = j;
    end
    return w;
  endfunction

endpackage

// File: rtl/regfile_if.sv
// rtl/regfile_if.sv - decode-stage register file port bundle
//
// Purpose : groups the read, write, reservation and flag signals of regfile_mp.
// Signals : rd_addr  NRD*AW   read addresses, port i at [i*AW +: AW]
//           rd_data  NRD*DW   read data, port i at [i*DW +: DW]
//           rd_busy  NRD      addressed register has a pending write
//           wr_tag   NWR*AW   write destination, 0 = no write
//           wr_data  NWR*DW   write data
//           rsv_tag  NRSV*AW  destination being issued, 0 = no reservation
//           o_flag   NFLAG    OR-reduction of the flag registers
// Modports: master drives addresses/tags/data, slave is the register file.
interface regfile_if import regfile_pkg::*; #(
  parameter int DW    = DW_DEF,
  parameter int NREG  = NREG_DEF,
  parameter int NRD   = 9,
  parameter int NWR   = 4,
  parameter int NRSV  = 4,
  parameter int NFLAG = 2
);
  localparam int AW = clog2_safe(NREG);

  logic [NRD*AW-1:0]  rd_addr;
  logic [NRD*DW-1:0]  rd_data;
  logic [NRD-1:0]     rd_busy;
  logic [NWR*AW-1:0]  wr_tag;
  logic [NWR*DW-1:0]  wr_data;
  logic [NRSV*AW-1:0] rsv_tag;
  logic [NFLAG-1:0]   o_flag;

  modport master (
    output rd_addr, wr_tag, wr_data, rsv_tag,
    input  rd_data, rd_busy, o_flag
  );

  modport slave (
    input  rd_addr, wr_tag, wr_data, rsv_tag,
    output rd_data, rd_busy, o_flag
  );

endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - write-pending scoreboard for regfile_mp
//
// Purpose : per-register busy bits, set by reservations and cleared by writes,
//           plus the per-read-port busy lookup.
// Ports   : clk, rst_n          clock, async active-low reset
//           wr_tag_i   NWR*AW   completing writes (clear busy)
//           rsv_tag_i  NRSV*AW  issuing producers (set busy)
//           rd_addr_i  NRD*AW   read addresses
//           rd_busy_o  NRD      busy state seen by each read port
module regfile_scoreboard import regfile_pkg::*; #(
  parameter int NREG   = NREG_DEF,
  parameter int NWR    = 4,
  parameter int NRSV   = 4,
  parameter int NRD    = 9,
  parameter int BYPASS = 1,
  parameter int AW     = clog2_safe(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR*AW-1:0]   wr_tag_i,
  input  logic [NRSV*AW-1:0]  rsv_tag_i,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD-1:0]      rd_busy_o
);

  // Register 0 never goes busy, so it has no state bit.
  logic [NREG-1:1] busy_q;
  logic [NREG-1:1] busy_d;
  logic [NREG-1:1] set_v;
  logic [NREG-1:1] clr_v;

  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int r = 1; r < NREG; r++) begin
      for (int k = 0; k < NRSV; k++) begin
        if (rsv_tag_i[k*AW +: AW] == AW'(r)) set_v[r] = 1'b1;
      end
      for (int j = 0; j < NWR; j++) begin
        if (wr_tag_i[j*AW +: AW] == AW'(r)) clr_v[r] = 1'b1;
      end
    end
    // A new producer supersedes the one completing in the same cycle.
    busy_d = set_v | (busy_q & ~clr_v);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // With bypass, a completing write (not re-reserved) already delivers the
  // data this cycle, so the reader must not stall on it.
  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_addr_i[i*AW +: AW] == AW'(r)) begin
          rd_busy_o[i] = busy_q[r] & ~((BYPASS != 0) & clr_v[r] & ~set_v[r]);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port decode-stage register file
//
// Purpose : NREG x DW storage with NWR write ports (highest port wins on
//           collision), NRD combinational read ports with optional write
//           bypass, a write-pending scoreboard and NFLAG nonzero flags.
// Ports   : clk    clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    regfile_if.slave (rd_addr/rd_data/rd_busy, wr_tag/wr_data,
//                  rsv_tag, o_flag)
module regfile_mp import regfile_pkg::*; #(
  parameter int DW        = DW_DEF,
  parameter int NREG      = NREG_DEF,
  parameter int NRD       = 9,
  parameter int NWR       = 4,
  parameter int NRSV      = 4,
  parameter int BYPASS    = 1,
  parameter int FLAG_BASE = 30,
  parameter int NFLAG     = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  regfile_if.slave bus
);

  localparam int AW = clog2_safe(NREG);

  // Register 0 reads as constant zero and has no storage.
  logic [DW-1:0]      regs_q   [1:NREG-1];
  logic [DW-1:0]      regs_d   [1:NREG-1];
  logic [MAX_NWR-1:0] port_hit [1:NREG-1];
  int                 wr_win   [1:NREG-1];
  logic [NREG-1:1]    wr_hit;
  logic [DW-1:0]      wr_val   [1:NREG-1];
  logic [NRD*DW-1:0]  rd_data;
  logic [NRD-1:0]     rd_busy;
  logic [NFLAG-1:0]   flag;

  // Per-register winning write; out-of-range tags match no register and drop.
  always_comb begin
    for (int r = 1; r < NREG; r++) begin
      port_hit[r] = '0;
      for (int j = 0; j < NWR; j++) begin
        if (bus.wr_tag[j*AW +: AW] == AW'(r)) port_hit[r][j] = 1'b1;
      end
      wr_win[r] = win_port(port_hit[r]);
      wr_hit[r] = |port_hit[r];
      wr_val[r] = '0;
      if (wr_hit[r]) wr_val[r] = bus.wr_data[wr_win[r]*DW +: DW];
      regs_d[r] = wr_hit[r] ? wr_val[r] : regs_q[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
    end else begin
      for (int r = 1; r < NREG; r++) regs_q[r] <= regs_d[r];
    end
  end

  // Address decode by match leaves register 0 and out-of-range addresses at 0.
  // Bypass is gated by rst_n so a reset mid-cycle also hides in-flight writes.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NRD; i++) begin
      for (int r = 1; r < NREG; r++) begin
        if (bus.rd_addr[i*AW +: AW] == AW'(r)) begin
          rd_data[i*DW +: DW] = ((BYPASS != 0) && rst_n && wr_hit[r]) ? wr_val[r] : regs_q[r];
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NWR    (NWR),
    .NRSV   (NRSV),
    .NRD    (NRD),
    .BYPASS (BYPASS),
    .AW     (AW)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_tag_i  (bus.wr_tag),
    .rsv_tag_i (bus.rsv_tag),
    .rd_addr_i (bus.rd_addr),
    .rd_busy_o (rd_busy)
  );

  // Flags see stored values only, so they trail the write by one cycle.
  for (genvar i = 0; i < NFLAG; i++) begin : g_flag
    assign flag[i] = |regs_q[FLAG_BASE+i];
  end

  assign bus.rd_data = rd_data;
  assign bus.rd_busy = rd_busy;
  assign bus.o_flag  = flag;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int DW    = 16;
  localparam int NREG  = 32;
  localparam int AW    = 5;
  localparam int NRD   = 9;
  localparam int NWR   = 4;
  localparam int NRSV  = 4;
  localparam int NFLAG = 2;

  logic clk = 1'b0;
  logic rst_n;

  logic [NRD*AW-1:0]  rd_addr;
  logic [NWR*AW-1:0]  wr_tag;
  logic [NWR*DW-1:0]  wr_data;
  logic [NRSV*AW-1:0] rsv_tag;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  regfile_if #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NRSV(NRSV), .NFLAG(NFLAG)) rf1 ();
  regfile_if #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NRSV(NRSV), .NFLAG(NFLAG)) rf0 ();

  assign rf1.rd_addr = rd_addr;
  assign rf1.wr_tag  = wr_tag;
  assign rf1.wr_data = wr_data;
  assign rf1.rsv_tag = rsv_tag;
  assign rf0.rd_addr = rd_addr;
  assign rf0.wr_tag  = wr_tag;
  assign rf0.wr_data = wr_data;
  assign rf0.rsv_tag = rsv_tag;

  regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NRSV(NRSV),
               .BYPASS(1), .FLAG_BASE(30), .NFLAG(NFLAG)) u_dut_byp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf1.slave)
  );

  regfile_mp #(.DW(DW), .NREG(NREG), .NRD(NRD), .NWR(NWR), .NRSV(NRSV),
               .BYPASS(0), .FLAG_BASE(30), .NFLAG(NFLAG)) u_dut_nobyp (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (rf0.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] rd1(input int i);
    return rf1.rd_data[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] rd0(input int i);
    return rf0.rd_data[i*DW +: DW];
  endfunction

  task automatic clr_wr();
    wr_tag  = '0;
    wr_data = '0;
    rsv_tag = '0;
  endtask

  task automatic set_rd(input int i, input logic [AW-1:0] a);
    rd_addr[i*AW +: AW] = a;
  endtask

  task automatic set_wr(input int j, input logic [AW-1:0] t, input logic [DW-1:0] d);
    wr_tag[j*AW +: AW]  = t;
    wr_data[j*DW +: DW] = d;
  endtask

  task automatic set_rsv(input int k, input logic [AW-1:0] t);
    rsv_tag[k*AW +: AW] = t;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    clr_wr();
    #3;
    check("rst_rd",   32'(rd1(0)), 32'h0);
    check("rst_busy", 32'(rf1.rd_busy), 32'h0);
    check("rst_flag", 32'(rf1.o_flag), 32'h0);
    #10 rst_n = 1'b1;
    tick();

    // Reset pulse mid-cycle clears stored, pending and in-flight state at once.
    set_wr(0, 5, 16'h1234);
    set_rsv(0, 7);
    tick();
    clr_wr();
    set_rd(0, 5);
    set_rd(1, 7);
    #1;
    check("pre_rst_data", 32'(rd1(0)), 32'h1234);
    check("pre_rst_busy", 32'(rf1.rd_busy[1]), 32'h1);
    set_wr(0, 5, 16'hBEEF);
    set_wr(1, 30, 16'h0001);
    rst_n = 1'b0;
    #1;
    check("rst_mid_data", 32'(rd1(0)), 32'h0);
    check("rst_mid_busy", 32'(rf1.rd_busy), 32'h0);
    check("rst_mid_flag", 32'(rf1.o_flag), 32'h0);
    clr_wr();
    rst_n = 1'b1;
    tick();
    check("post_rst_data", 32'(rd1(0)), 32'h0);
    check("post_rst_busy", 32'(rf1.rd_busy), 32'h0);

    // Collision: highest write port wins, in storage and in bypass.
    rd_addr = '0;
    set_rd(0, 9);
    set_wr(0, 9, 16'hAAAA);
    set_wr(3, 9, 16'h5555);
    #1;
    check("col_byp",   32'(rd1(0)), 32'h5555);
    check("col_nobyp", 32'(rd0(0)), 32'h0);
    tick();
    clr_wr();
    #1;
    check("col_next",    32'(rd1(0)), 32'h5555);
    check("col_next_nb", 32'(rd0(0)), 32'h5555);
    check("col_busy",    32'(rf1.rd_busy[0]), 32'h0);
    set_wr(1, 9, 16'h1111);
    set_wr(2, 9, 16'h2222);
    #1;
    check("col2_byp", 32'(rd1(0)), 32'h2222);
    tick();
    clr_wr();
    #1;
    check("col2_next", 32'(rd0(0)), 32'h2222);

    // Register 0: tag 0 writes and reservations are ignored.
    set_rd(0, 0);
    set_rd(1, 9);
    set_rd(2, 5);
    set_wr(0, 0, 16'hFFFF);
    set_rsv(0, 0);
    #1;
    check("r0_rd",   32'(rd1(0)), 32'h0);
    check("r0_busy", 32'(rf1.rd_busy[0]), 32'h0);
    tick();
    clr_wr();
    #1;
    check("r0_rd_next",   32'(rd1(0)), 32'h0);
    check("r0_busy_next", 32'(rf1.rd_busy), 32'h0);
    check("r0_other9",    32'(rd1(1)), 32'h2222);
    check("r0_other5",    32'(rd1(2)), 32'h0);

    // Scoreboard set / reserve-wins / clear sequence on reg12.
    rd_addr = '0;
    set_rd(0, 12);
    set_rsv(0, 12);
    #1;
    check("sb_same", 32'(rf1.rd_busy[0]), 32'h0);
    tick();
    clr_wr();
    #1;
    check("sb_set", 32'(rf1.rd_busy[0]), 32'h1);
    set_wr(0, 12, 16'h0C0C);
    set_rsv(1, 12);
    #1;
    check("sb_m_busy", 32'(rf1.rd_busy[0]), 32'h1);
    check("sb_m_data", 32'(rd1(0)), 32'h0C0C);
    tick();
    clr_wr();
    #1;
    check("sb_m1", 32'(rf1.rd_busy[0]), 32'h1);
    tick();
    set_wr(0, 12, 16'h0D0D);
    #1;
    check("sb_m2_byp",   32'(rf1.rd_busy[0]), 32'h0);
    check("sb_m2_nobyp", 32'(rf0.rd_busy[0]), 32'h1);
    tick();
    clr_wr();
    #1;
    check("sb_m3",    32'(rf1.rd_busy[0]), 32'h0);
    check("sb_m3_nb", 32'(rf0.rd_busy[0]), 32'h0);
    set_rd(1, 13);
    set_rsv(0, 13);
    set_rsv(3, 13);
    tick();
    clr_wr();
    #1;
    check("sb_dup",   32'(rf1.rd_busy[1]), 32'h1);
    check("sb_dup12", 32'(rf1.rd_busy[0]), 32'h0);

    // Bypass off: same-cycle read sees the old value.
    rd_addr = '0;
    set_rd(0, 3);
    set_wr(0, 3, 16'h00F0);
    #1;
    check("nb_same", 32'(rd0(0)), 32'h0);
    check("nb_byp",  32'(rd1(0)), 32'h00F0);
    tick();
    clr_wr();
    #1;
    check("nb_next", 32'(rd0(0)), 32'h00F0);

    // Flags follow stored values one cycle after each write.
    set_wr(0, 30, 16'h0001);
    #1;
    check("fl_same", 32'(rf1.o_flag), 32'h0);
    tick();
    clr_wr();
    #1;
    check("fl_1", 32'(rf1.o_flag), 32'h1);
    set_wr(0, 31, 16'h8000);
    #1;
    check("fl_2pre", 32'(rf1.o_flag), 32'h1);
    tick();
    clr_wr();
    #1;
    check("fl_2", 32'(rf1.o_flag), 32'h3);
    set_wr(0, 30, 16'h0000);
    tick();
    clr_wr();
    #1;
    check("fl_3",    32'(rf1.o_flag), 32'h2);
    check("fl_3_nb", 32'(rf0.o_flag), 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
